// File: rtl/present_load_ctrl.sv
// present_load_ctrl
//   Byte-stream front end and result catcher for a PRESENT-80 cipher core.
//   Collects an 80-bit key (10 bytes) and a 64-bit plaintext (8 bytes), MSB first,
//   from an 8-bit valid/ready stream. Holds them stable on keys/state while the
//   cipher works, waits CIPHER_LATENCY cycles, captures result and offers it on a
//   valid/ready output. key_reuse (sampled at the output handshake) skips the key
//   phase of the next block.
//
// Ports
//   sys_clk   in      clock, rising edge
//   sys_rst   in      asynchronous active-low reset
//   in_data   in  8   key / plaintext byte
//   in_valid  in      in_data valid
//   in_ready  out     byte accepted this cycle (S_KEY / S_PT only)
//   key_reuse in      next block reuses the current key
//   state     out 64  plaintext to the cipher, bit 0 = MSB
//   keys      out 80  key to the cipher, bit 0 = MSB
//   result    in  64  ciphertext from the cipher
//   out_ct    out 64  captured ciphertext
//   out_valid out     out_ct valid
//   out_ready in      consumer accepts out_ct
//   busy      out     high while waiting on the cipher or holding a result
module present_load_ctrl #(
  parameter int unsigned CIPHER_LATENCY = 32
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        key_reuse,
  output logic [0:63] state,
  output logic [0:79] keys,
  input  logic [0:63] result,
  output logic [0:63] out_ct,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {SKey, SPt, SWait, SOut} fsm_e;

  localparam logic [7:0] LatLast = 8'(CIPHER_LATENCY - 1);

  fsm_e        fsm_q, fsm_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  lat_cnt_q, lat_cnt_d;
  logic [0:79] keys_q, keys_d;
  logic [0:63] state_q, state_d;
  logic [0:63] out_ct_q, out_ct_d;
  logic        out_valid_q, out_valid_d;
  logic        accept;

  // Decoded from state only so there is no in_valid -> in_ready path.
  assign in_ready  = (fsm_q == SKey) || (fsm_q == SPt);
  assign busy      = (fsm_q == SWait) || (fsm_q == SOut);
  assign accept    = in_valid & in_ready;

  assign keys      = keys_q;
  assign state     = state_q;
  assign out_ct    = out_ct_q;
  assign out_valid = out_valid_q;

  always_comb begin
    fsm_d       = fsm_q;
    byte_cnt_d  = byte_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    keys_d      = keys_q;
    state_d     = state_q;
    out_ct_d    = out_ct_q;
    out_valid_d = out_valid_q;
    unique case (fsm_q)
      SKey: begin
        if (accept) begin
          keys_d = {keys_q[8:79], in_data};
          if (byte_cnt_q == 4'd9) begin
            fsm_d      = SPt;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end
      SPt: begin
        if (accept) begin
          state_d = {state_q[8:63], in_data};
          if (byte_cnt_q == 4'd7) begin
            fsm_d     = SWait;
            lat_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end
      SWait: begin
        lat_cnt_d = lat_cnt_q + 8'd1;
        // Counter starts at 0 the cycle after the last byte, so this edge is
        // exactly CIPHER_LATENCY edges after that byte was accepted.
        if (lat_cnt_q == LatLast) begin
          out_ct_d    = result;
          out_valid_d = 1'b1;
          fsm_d       = SOut;
        end
      end
      SOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = key_reuse ? SPt : SKey;
          byte_cnt_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      fsm_q       <= SKey;
      byte_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      keys_q      <= '0;
      state_q     <= '0;
      out_ct_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      byte_cnt_q  <= byte_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      keys_q      <= keys_d;
      state_q     <= state_d;
      out_ct_q    <= out_ct_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_present_load_ctrl.sv
// Testbench for present_load_ctrl: a behavioural PRESENT-80 core (or a
// pass-through stub) that only presents the right answer once its inputs have
// been stable for LAT cycles, a table of blocks, and hand-written reset cases.
module tb_present_load_ctrl;

  localparam int LAT = 12;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        key_reuse;
  logic [0:63] state;
  logic [0:79] keys;
  logic [0:63] result;
  logic [0:63] out_ct;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  present_load_ctrl #(.CIPHER_LATENCY(LAT)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key_reuse (key_reuse),
    .state     (state),
    .keys      (keys),
    .result    (result),
    .out_ct    (out_ct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;
  int unsigned last_acc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // ---------------- cipher model ----------------
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'hC56B90AD3EF84712;
    return tbl[60 - 4 * int'(x) +: 4];
  endfunction

  function automatic logic [63:0] present_enc(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox(s[4*n +: 4]);
      t = '0;
      for (int b = 0; b < 63; b++) t[(16 * b) % 63] = s[b];
      t[63] = s[63];
      s = t;
      k = {k[18:0], k[79:19]};
      k[79:76] = sbox(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  bit           stub = 1'b0;
  logic [143:0] snap = '1;
  int           stab = 0;
  logic [63:0]  ct_ok;

  // stab reaches LAT-1 just before the LAT-th edge after the inputs settled.
  always @(negedge sys_clk) begin
    if ({state, keys} !== snap) begin
      snap <= {state, keys};
      stab <= 0;
    end else if (stab < 100000) begin
      stab <= stab + 1;
    end
  end

  always_comb begin
    ct_ok  = stub ? state : present_enc(state, keys);
    result = (stab >= LAT - 1) ? ct_ok : ~ct_ok;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [63:0] ct;
    logic [79:0] keys;
    logic [63:0] pt;
    int unsigned acc;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard = 0;
    if (gaps) begin
      for (int g = 0; g < 3 && $urandom_range(1, 0) == 1; g++) begin
        in_valid = 1'b0;
        @(negedge sys_clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 100) begin
      @(negedge sys_clk);
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 128'(in_ready), 128'(1));
      in_valid = 1'b0;
      return;
    end
    @(posedge sys_clk);
    last_acc = cyc;
    @(negedge sys_clk);
    in_valid = 1'b0;
  endtask

  task automatic run_block(input logic [79:0] key, input logic [63:0] pt, input bit send_key,
                           input bit gaps, input bit stub_mode, input logic [63:0] ct,
                           input logic [79:0] exp_keys);
    exp_t e;
    stub = stub_mode;
    if (send_key) for (int i = 0; i < 10; i++) send_byte(key[79 - 8 * i -: 8], gaps);
    for (int i = 0; i < 8; i++) send_byte(pt[63 - 8 * i -: 8], gaps);
    e.ct = ct;
    e.keys = exp_keys;
    e.pt = pt;
    e.acc = last_acc;
    exp_q.push_back(e);
    check("keys_loaded", 128'(keys), 128'(exp_keys));
    check("state_loaded", 128'(state), 128'(pt));
    check("ready_busy_after_block", 128'({in_ready, busy}), 128'(2'b01));
  endtask

  task automatic finish_block(input int hold, input bit reuse, input bit flood);
    int   guard = 0;
    bit   seen = 0;
    bit   stable = 1;
    exp_t e;
    logic [63:0] ct0;
    in_valid = flood;
    in_data  = 8'hA5;
    while (guard < LAT + 20) begin
      @(negedge sys_clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
      guard++;
    end
    in_valid = 1'b0;
    if (!seen) begin
      check("out_valid_timeout", 128'(out_valid), 128'(1));
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    check("latency", 128'(cyc - e.acc - 1), 128'(LAT));
    check("out_ct", 128'(out_ct), 128'(e.ct));
    check("keys_held", 128'(keys), 128'(e.keys));
    check("state_held", 128'(state), 128'(e.pt));
    ct0 = out_ct;
    for (int i = 0; i < hold; i++) begin
      @(negedge sys_clk);
      if (!out_valid || out_ct !== ct0 || in_ready || !busy) stable = 0;
    end
    if (hold > 0) check("backpressure_stable", 128'(stable), 128'(1));
    out_ready = 1'b1;
    key_reuse = reuse;
    @(posedge sys_clk);
    #1;
    check("out_valid_falls", 128'(out_valid), 128'(0));
    check("in_ready_after_hs", 128'({in_ready, busy}), 128'(2'b10));
    out_ready = 1'b0;
    key_reuse = 1'b0;
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_keys"}, 128'(keys), 128'(0));
    check({name, "_state"}, 128'(state), 128'(0));
    check({name, "_out_ct"}, 128'(out_ct), 128'(0));
    check({name, "_flags"}, 128'({out_valid, busy, in_ready}), 128'(3'b001));
  endtask

  typedef struct {
    logic [79:0] key;
    logic [63:0] pt;
    bit          send_key;
    bit          gaps;
    bit          stub;
    bit          reuse;
    int          hold;
    bit          flood;
    logic [63:0] ct;
    logic [79:0] exp_keys;
  } vec_t;
  vec_t vecs[6];

  localparam logic [79:0] KOnes = {80{1'b1}};
  localparam logic [63:0] POnes = {64{1'b1}};
  localparam logic [79:0] KSeq  = 80'h00010203040506070809;
  localparam logic [63:0] PSeq  = 64'h1011121314151617;

  initial begin
    vecs[0] = '{'0,    '0,    1, 0, 0, 1, 0,  0, 64'h5579C1387B228445, '0};
    vecs[1] = '{'0,    POnes, 0, 0, 0, 0, 50, 1, 64'hA112FFC72F68417B, '0};
    vecs[2] = '{KOnes, POnes, 1, 0, 0, 0, 0,  0, 64'h3333DCD3213210D2, KOnes};
    vecs[3] = '{KOnes, POnes, 1, 1, 0, 0, 0,  1, 64'h3333DCD3213210D2, KOnes};
    vecs[4] = '{KOnes, '0,    1, 1, 0, 0, 0,  0, 64'hE72C46C0F5945049, KOnes};
    vecs[5] = '{KSeq,  PSeq,  1, 0, 1, 0, 0,  0, PSeq,                 KSeq};

    sys_rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    key_reuse = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_reset_vals("reset");
    sys_rst = 1'b1;
    @(negedge sys_clk);

    for (int i = 0; i < 6; i++) begin
      run_block(vecs[i].key, vecs[i].pt, vecs[i].send_key, vecs[i].gaps, vecs[i].stub,
                vecs[i].ct, vecs[i].exp_keys);
      finish_block(vecs[i].hold, vecs[i].reuse, vecs[i].flood);
    end

    // Reset after five key bytes; must clear asynchronously, no clock edge.
    stub = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(8'h5A + 8'(i), 1'b0);
    #2 sys_rst = 1'b0;
    #1 check_reset_vals("rst_in_key");
    @(negedge sys_clk);
    sys_rst = 1'b1;
    run_block(KOnes, '0, 1, 0, 0, 64'hE72C46C0F5945049, KOnes);
    finish_block(0, 0, 0);

    // Reset while the cipher is running.
    run_block('0, POnes, 1, 0, 0, 64'hA112FFC72F68417B, '0);
    repeat (4) @(negedge sys_clk);
    check("wait_no_valid", 128'({out_valid, busy}), 128'(2'b01));
    #2 sys_rst = 1'b0;
    #1 check_reset_vals("rst_in_wait");
    exp_q.delete();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    run_block('0, '0, 1, 0, 0, 64'h5579C1387B228445, '0);
    finish_block(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
